// File: rtl/srec_loader.sv
// Motorola S-record (S0/S1/S9) ASCII parser that streams data bytes into a byte-wide
// program memory, verifies checksums and captures the S9 start address.
module srec_loader #(
    parameter int ADDR_W = 16,
    parameter bit LC_HEX = 1'b1
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic [7:0]        Rx_data,
    input  logic              Rx_valid,
    output logic [ADDR_W-1:0] Mem_addr,
    output logic [7:0]        Mem_data,
    output logic              Mem_we,
    output logic [15:0]       Start_addr,
    output logic [15:0]       Rec_count,
    output logic              Done,
    output logic              Err_cksum,
    output logic              Err_format
);

    typedef enum logic [2:0] {
        S_IDLE, S_TYPE, S_COUNT, S_ADDR, S_DATA, S_CKSUM, S_DONE
    } state_t;

    typedef enum logic [1:0] {REC_S0, REC_S1, REC_S9} rec_t;

    state_t      state;
    rec_t        rec;
    logic        have_hi;
    logic [3:0]  hi_nib;
    logic        addr_second;
    logic [7:0]  count;
    logic [7:0]  remain;
    logic [7:0]  sum;
    logic [15:0] ptr;

    logic        is_hex;
    logic [3:0]  nib;
    logic [7:0]  byte_val;
    logic [7:0]  sum_next;

    // NOTE: every variable gets a default before the if-chain so no latch is inferred.
    always_comb begin
        is_hex = 1'b1;
        nib    = 4'h0;
        if (Rx_data >= "0" && Rx_data <= "9")
            nib = Rx_data[3:0];
        else if (Rx_data >= "A" && Rx_data <= "F")
            nib = Rx_data[3:0] + 4'd9;
        else if (LC_HEX && Rx_data >= "a" && Rx_data <= "f")
            nib = Rx_data[3:0] + 4'd9;
        else
            is_hex = 1'b0;
    end

    assign byte_val = {hi_nib, nib};
    assign sum_next = sum + byte_val;

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state       <= S_IDLE;
            rec         <= REC_S0;
            have_hi     <= 1'b0;
            hi_nib      <= 4'h0;
            addr_second <= 1'b0;
            count       <= 8'h00;
            remain      <= 8'h00;
            sum         <= 8'h00;
            ptr         <= 16'h0000;
            Mem_addr    <= '0;
            Mem_data    <= 8'h00;
            Mem_we      <= 1'b0;
            Start_addr  <= 16'h0000;
            Rec_count   <= 16'h0000;
            Done        <= 1'b0;
            Err_cksum   <= 1'b0;
            Err_format  <= 1'b0;
        end else begin
            Mem_we <= 1'b0;
            if (Rx_valid) begin
                case (state)
                    S_IDLE: if (Rx_data == "S") state <= S_TYPE;
                    S_TYPE: begin
                        have_hi <= 1'b0;
                        sum     <= 8'h00;
                        state   <= S_COUNT;
                        case (Rx_data)
                            "0":     rec <= REC_S0;
                            "1":     rec <= REC_S1;
                            "9":     rec <= REC_S9;
                            default: begin
                                Err_format <= 1'b1;
                                state      <= S_IDLE;
                            end
                        endcase
                    end
                    S_DONE: ;
                    default: begin
                        if (!is_hex) begin
                            // A stray 'S' most likely starts the next record, so resync on it.
                            Err_format <= 1'b1;
                            have_hi    <= 1'b0;
                            state      <= (Rx_data == "S") ? S_TYPE : S_IDLE;
                        end else if (!have_hi) begin
                            hi_nib  <= nib;
                            have_hi <= 1'b1;
                        end else begin
                            have_hi <= 1'b0;
                            sum     <= sum_next;
                            case (state)
                                S_COUNT: begin
                                    count       <= byte_val;
                                    addr_second <= 1'b0;
                                    if (byte_val < 8'd3 || (rec == REC_S9 && byte_val != 8'd3)) begin
                                        Err_format <= 1'b1;
                                        state      <= S_IDLE;
                                    end else begin
                                        state <= S_ADDR;
                                    end
                                end
                                S_ADDR: begin
                                    if (!addr_second) begin
                                        ptr[15:8]   <= byte_val;
                                        addr_second <= 1'b1;
                                    end else begin
                                        ptr[7:0] <= byte_val;
                                        remain   <= count - 8'd3;
                                        state    <= (count == 8'd3) ? S_CKSUM : S_DATA;
                                    end
                                end
                                S_DATA: begin
                                    if (rec == REC_S1) begin
                                        Mem_we   <= 1'b1;
                                        Mem_addr <= ptr[ADDR_W-1:0];
                                        Mem_data <= byte_val;
                                        ptr      <= ptr + 16'd1;
                                    end
                                    remain <= remain - 8'd1;
                                    if (remain == 8'd1) state <= S_CKSUM;
                                end
                                S_CKSUM: begin
                                    state <= S_IDLE;
                                    if (sum_next == 8'hFF) begin
                                        if (rec == REC_S1) Rec_count <= Rec_count + 16'd1;
                                        if (rec == REC_S9) begin
                                            Start_addr <= ptr;
                                            Done       <= 1'b1;
                                            state      <= S_DONE;
                                        end
                                    end else begin
                                        Err_cksum <= 1'b1;
                                    end
                                end
                                default: state <= S_IDLE;
                            endcase
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_srec_loader.sv
// Self-checking bench for srec_loader: directed S-record streams plus randomized
// record streams scored against a record-level reference model.
module tb_srec_loader;

    logic        Clock = 1'b0;
    logic        Reset_n;
    logic [7:0]  Rx_data;
    logic        Rx_valid;
    logic [15:0] Mem_addr;
    logic [7:0]  Mem_data;
    logic        Mem_we;
    logic [15:0] Start_addr;
    logic [15:0] Rec_count;
    logic        Done;
    logic        Err_cksum;
    logic        Err_format;

    srec_loader #(.ADDR_W(16), .LC_HEX(1'b1)) dut (
        .Clock(Clock), .Reset_n(Reset_n), .Rx_data(Rx_data), .Rx_valid(Rx_valid),
        .Mem_addr(Mem_addr), .Mem_data(Mem_data), .Mem_we(Mem_we),
        .Start_addr(Start_addr), .Rec_count(Rec_count), .Done(Done),
        .Err_cksum(Err_cksum), .Err_format(Err_format)
    );

    always #5 Clock = ~Clock;

    int n_checks = 0;
    int n_errors = 0;
    bit gaps = 1'b0;

    logic [23:0] obs_q[$];
    logic [23:0] exp_q[$];
    logic [15:0] m_rec;
    logic [15:0] m_start;
    bit          m_done, m_ck, m_fmt;

    always @(negedge Clock)
        if (Reset_n === 1'b1 && Mem_we === 1'b1) obs_q.push_back({Mem_addr, Mem_data});

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic clear_model();
        obs_q.delete();
        exp_q.delete();
        m_rec = 16'h0; m_start = 16'h0; m_done = 0; m_ck = 0; m_fmt = 0;
    endtask

    task automatic do_reset();
        Reset_n  = 1'b0;
        Rx_valid = 1'b0;
        repeat (2) @(negedge Clock);
        clear_model();
        Reset_n = 1'b1;
        @(negedge Clock);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            if (gaps) repeat ($urandom_range(0, 3)) begin
                @(negedge Clock);
                Rx_valid = 1'b0;
            end
            @(negedge Clock);
            Rx_data  = s[i];
            Rx_valid = 1'b1;
        end
        @(negedge Clock);
        Rx_valid = 1'b0;
        repeat (2) @(negedge Clock);
    endtask

    task automatic check_writes(input string tag);
        int n;
        check({tag, ".nwrites"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s.write%0d", tag, i), obs_q[i], exp_q[i]);
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic check_status(input string tag);
        check({tag, ".rec_count"},  Rec_count,  m_rec);
        check({tag, ".done"},       Done,       m_done);
        check({tag, ".start_addr"}, Start_addr, m_done ? m_start : 16'h0);
        check({tag, ".err_cksum"},  Err_cksum,  m_ck);
        check({tag, ".err_format"}, Err_format, m_fmt);
    endtask

    function automatic string hx(input logic [7:0] b, input bit lc);
        if (lc) return $sformatf("%02x", b);
        return $sformatf("%02X", b);
    endfunction

    // Builds one record and records what it must do to memory and status.
    task automatic make_rec(input logic [7:0] t, input logic [15:0] a, input int n,
                            input bit good, output string s);
        logic [7:0]  cnt, sum, d, ck;
        logic [15:0] p;
        bit lc;
        lc  = 1'($urandom_range(0, 1));
        cnt = 8'(n + 3);
        p   = a;
        s   = $sformatf("S%c", t);
        s   = {s, hx(cnt, lc), hx(a[15:8], lc), hx(a[7:0], lc)};
        sum = cnt + a[15:8] + a[7:0];
        for (int i = 0; i < n; i++) begin
            d   = 8'($urandom);
            s   = {s, hx(d, lc)};
            sum = sum + d;
            if (t == "1" && !m_done) begin
                exp_q.push_back({p, d});
                p = p + 16'd1;
            end
        end
        ck = ~sum;
        if (!good) ck = ck ^ 8'h01;
        s = {s, hx(ck, lc)};
        if (!m_done) begin
            if (!good) m_ck = 1;
            else if (t == "1") m_rec = m_rec + 16'd1;
            else if (t == "9") begin
                m_done  = 1;
                m_start = a;
            end
        end
    endtask

    initial begin
        string s;
        int kind;
        Reset_n  = 1'b0;
        Rx_valid = 1'b0;
        Rx_data  = 8'h00;

        do_reset();
        check("reset.mem_we", Mem_we, 1'b0);
        check("reset.mem_addr", Mem_addr, 16'h0);
        check_status("reset");

        // 1: basic good S1
        send_str("S1050010AB122D\r\n");
        exp_q.push_back({16'h0010, 8'hAB}); exp_q.push_back({16'h0011, 8'h12});
        m_rec = 1;
        check_writes("t1"); check_status("t1");

        // 2: bad checksum, writes still issued
        do_reset();
        send_str("S1050010AB122E");
        exp_q.push_back({16'h0010, 8'hAB}); exp_q.push_back({16'h0011, 8'h12});
        m_ck = 1;
        check_writes("t2"); check_status("t2");

        // 3: address wrap
        do_reset();
        send_str("S105FFFF1122C9");
        exp_q.push_back({16'hFFFF, 8'h11}); exp_q.push_back({16'h0000, 8'h22});
        m_rec = 1;
        check_writes("t3"); check_status("t3");

        // 4: S9 then everything ignored
        do_reset();
        send_str("S9030100FB");
        send_str("S1050010AB122D");
        m_done = 1; m_start = 16'h0100;
        check_writes("t4"); check_status("t4");

        // 5: illegal hex char, parser recovers
        do_reset();
        send_str("S10500G0...S1050010AB122D");
        exp_q.push_back({16'h0010, 8'hAB}); exp_q.push_back({16'h0011, 8'h12});
        m_fmt = 1; m_rec = 1;
        check_writes("t5"); check_status("t5");

        // 5b: short count and bad S9 count, plus 'S' resync mid-record
        send_str("S1020000\r\nS904010000FA\r\nS1050S1050010AB122D");
        exp_q.push_back({16'h0010, 8'hAB}); exp_q.push_back({16'h0011, 8'h12});
        m_rec = 2;
        check_writes("t5b"); check_status("t5b");

        // 6: reset in mid-record clears every output
        send_str("S105001");
        Reset_n = 1'b0;
        #3;
        check("t6.mem_we", Mem_we, 1'b0);
        check("t6.mem_addr", Mem_addr, 16'h0);
        check("t6.mem_data", Mem_data, 8'h0);
        check("t6.rec_count", Rec_count, 16'h0);
        check("t6.err_format", Err_format, 1'b0);
        do_reset();
        send_str("S1050010AB122D\r\n");
        exp_q.push_back({16'h0010, 8'hAB}); exp_q.push_back({16'h0011, 8'h12});
        m_rec = 1;
        check_writes("t6"); check_status("t6");

        // Randomized record streams, back-to-back first, then with idle gaps
        for (int round = 0; round < 4; round++) begin
            do_reset();
            gaps = (round != 0);
            for (int k = 0; k < 15; k++) begin
                kind = $urandom_range(0, 9);
                if (kind <= 6)
                    make_rec("1", ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom),
                             $urandom_range(0, 5), $urandom_range(0, 4) != 0, s);
                else if (kind == 7)
                    make_rec("0", 16'h0000, $urandom_range(0, 4), $urandom_range(0, 3) != 0, s);
                else if (kind == 8) begin
                    s = ($urandom_range(0, 1) == 1) ? "S5" : "S10Z";
                    m_fmt = 1;
                end else
                    s = "\r\n ";
                if ($urandom_range(0, 1) == 1) s = {s, "\r\n"};
                send_str(s);
            end
            make_rec("9", 16'($urandom), 0, 1'b1, s);
            send_str(s);
            make_rec("1", 16'($urandom), 3, 1'b1, s);
            send_str(s);
            check_writes($sformatf("rnd%0d", round));
            check_status($sformatf("rnd%0d", round));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
